// File: rtl/four_way_clmul_seq.sv
// Sequential 4-way split carry-less multiplier: seven limb diagonals accumulated R bits per cycle, then recombined.
// Optional feature macro CLMUL_ACC_EN adds the acc port (c <= c ^ product when requested).
module four_way_clmul_seq #(
  parameter int A_W = 32,
  parameter int B_W = 41,
  parameter int R   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
`ifdef CLMUL_ACC_EN
  input  logic                 acc,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [A_W+B_W-1:0]   c
);

  localparam int MAX_W = (A_W > B_W) ? A_W : B_W;
  localparam int L     = (MAX_W + 3) / 4;
  localparam int C_W   = A_W + B_W;
  localparam int DW    = 2 * L - 1;
  localparam int PW    = 8 * L;
  localparam int CNT_W = $clog2(L + 1);

  if (L % R != 0) begin : g_bad_r
    $error("four_way_clmul_seq: R must divide the limb width L");
  end

  typedef enum logic [1:0] {IDLE, RUN, COMB} state_t;

  state_t             state_reg, state_next;
  logic [4*L-1:0]     a_reg, b_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [C_W-1:0]     c_reg;
  logic               done_reg;
  logic               load;
  logic               last_step;
  logic [DW-1:0]      diag [7];
  logic [C_W-1:0]     prod;
`ifdef CLMUL_ACC_EN
  logic               acc_reg;
`endif

  assign load      = (state_reg == IDLE) && start;
  assign last_step = (cnt_reg + CNT_W'(R)) == CNT_W'(L);

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = COMB;
      end
      COMB: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      c_reg     <= '0;
      done_reg  <= 1'b0;
`ifdef CLMUL_ACC_EN
      acc_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == COMB);
      if (load) begin
        a_reg   <= (4*L)'(a);
        b_reg   <= (4*L)'(b);
        cnt_reg <= '0;
`ifdef CLMUL_ACC_EN
        acc_reg <= acc;
`endif
      end
      if (state_reg == RUN) begin
        cnt_reg <= last_step ? '0 : cnt_reg + CNT_W'(R);
      end
      if (state_reg == COMB) begin
`ifdef CLMUL_ACC_EN
        c_reg <= acc_reg ? (c_reg ^ prod) : prod;
`else
        c_reg <= prod;
`endif
      end
    end
  end

  // One register per diagonal k; each step folds in bit positions cnt..cnt+R-1 of every a limb i with i+j=k.
  for (genvar gi = 0; gi < 7; gi++) begin : g_diag
    logic [DW-1:0] d_reg, d_next;

    always_comb begin
      d_next = d_reg;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (i + j == gi) begin
            for (int t = 0; t < R; t++) begin
              if (a_reg[i*L + int'(cnt_reg) + t])
                d_next = d_next ^ (DW'(b_reg[j*L +: L]) << (int'(cnt_reg) + t));
            end
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || load) begin
        d_reg <= '0;
      end else if (state_reg == RUN) begin
        d_reg <= d_next;
      end
    end

    assign diag[gi] = d_reg;
  end

  always_comb begin
    prod = '0;
    for (int k = 0; k < 7; k++) begin
      prod = prod ^ C_W'(PW'(diag[k]) << (k * L));
    end
  end

  assign done = done_reg;
  assign c    = c_reg;

endmodule

// File: tb/tb_four_way_clmul_seq.sv
// Randomized self-checking bench for four_way_clmul_seq against a shift-and-XOR carry-less product model.
// Honours CLMUL_ACC_EN (acc port and accumulate model) and the R_P parameter (limb bits per cycle).
module tb_four_way_clmul_seq #(
  parameter int R_P = 1
);

  localparam int A_W = 32;
  localparam int B_W = 41;
  localparam int C_W = A_W + B_W;
  localparam int L   = 11;
  localparam int LAT = L / R_P + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             acc;
  logic             busy;
  logic             done;
  logic [C_W-1:0]   c;

  int               vectors = 0;
  int               miscompares = 0;
  logic [C_W-1:0]   exp_c = '0;

  always #5 clk = ~clk;

  four_way_clmul_seq #(.A_W(A_W), .B_W(B_W), .R(R_P)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef CLMUL_ACC_EN
    .acc   (acc),
`endif
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  function automatic logic [C_W-1:0] clmul_ref(input logic [A_W-1:0] x, input logic [B_W-1:0] y);
    logic [C_W-1:0] r;
    r = '0;
    for (int i = 0; i < A_W; i++)
      if (x[i]) r = r ^ (C_W'(y) << i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Starts one operation at a falling edge and returns at the falling edge where done is seen.
  // If poke >= 0, a second start with other operands is pulsed that many cycles into the run.
  task automatic run_op(input string tag, input logic [A_W-1:0] aa, input logic [B_W-1:0] bb,
                        input logic ac, input int poke);
    int lat;
    logic [C_W-1:0] prod;
    a = aa; b = bb; start = 1'b1; acc = ac;
    @(negedge clk);
    lat = 0;
    start = 1'b0;
    check({tag, "_busy"}, 128'(busy), 128'(1'b1));
    while (!done && lat < 200) begin
      if (lat == poke) begin
        a = ~aa; b = ~bb; start = 1'b1; acc = ~ac;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    prod = clmul_ref(aa, bb);
`ifdef CLMUL_ACC_EN
    exp_c = ac ? (exp_c ^ prod) : prod;
`else
    exp_c = prod;
`endif
    check({tag, "_lat"}, 128'(lat), 128'(LAT));
    check({tag, "_c"}, 128'(c), 128'(exp_c));
    $display("op %s a=%h b=%h acc=%0b lat=%0d c=%h", tag, aa, bb, ac, lat, c);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; acc = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_c", 128'(c), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op("one", 32'h1, 41'h1, 1'b0, -1);
    @(negedge clk);
    check("done_pulse", 128'(done), 128'(0));
    run_op("three", 32'h3, 41'h3, 1'b0, -1);
    check("three_val", 128'(c), 128'h5);
    run_op("allones", 32'hFFFF_FFFF, 41'h1, 1'b0, -1);
    check("allones_val", 128'(c), 128'hFFFF_FFFF);
    run_op("topbits", 32'h8000_0000, 41'h100_0000_0000, 1'b0, -1);
    check("topbits_val", 128'(c), 128'(1) << 71);
    check("bit72", 128'(c[C_W-1]), 128'(0));

    // start pulsed mid-run, then back-to-back start in the done cycle
    run_op("poke", 32'hDEAD_BEEF, 41'h1AB_CDEF_0123, 1'b0, 3);
    run_op("b2b", 32'h1234_5678, 41'h0F0_F0F0_F0F0, 1'b0, -1);

    // reset at cycle 5 of RUN discards the operation
    a = 32'hCAFE_F00D; b = 41'h155_5555_5555; start = 1'b1; acc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    check("midrst_c", 128'(c), 128'(0));
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_nodone", 128'(ndone), 128'(0));
    exp_c = '0;

`ifdef CLMUL_ACC_EN
    run_op("acc1", 32'h3, 41'h3, 1'b0, -1);
    check("acc1_val", 128'(c), 128'h5);
    run_op("acc2", 32'h1, 41'h1, 1'b1, -1);
    check("acc2_val", 128'(c), 128'h4);
`endif

    for (int n = 0; n < 1500; n++) begin
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;
      ra = $urandom;
      rb = {9'($urandom), $urandom};
      if (n % 16 == 0) ra = '0;
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
